// File: rtl/dffnrnq_pkg.sv
// Shared constants and helpers for the negative-edge pipeline register bank.
package dffnrnq_pkg;

    localparam logic RESET_VAL_DEFAULT = 1'b0;

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffnrnq_pipe_bank_if.sv
// Data/valid/control bundle of the negative-edge pipeline bank.
interface dffnrnq_pipe_bank_if
    import dffnrnq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic                      EN;
    logic                      FLUSH;
    logic [WIDTH-1:0]          D;
    logic                      DV;
    logic [WIDTH-1:0]          Q;
    logic                      QV;
    logic [occ_w(DEPTH)-1:0]   OCC;

    modport master (output EN, FLUSH, D, DV, input Q, QV, OCC);
    modport slave  (input EN, FLUSH, D, DV, output Q, QV, OCC);
endinterface

// File: rtl/dffnrnq_vec.sv
// One falling-edge register of W bits: async active-low clear, synchronous
// load-constant, and enable.
module dffnrnq_vec #(
    parameter int unsigned   W        = 1,
    parameter logic [W-1:0]  LOAD_VAL = '0
) (
    input  logic         CLKN,
    input  logic         RN,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            Q <= LOAD_VAL;
        end else if (LOAD) begin
            Q <= LOAD_VAL;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/dffnrnq_pipe_bank.sv
// DEPTH-stage falling-edge pipeline of WIDTH-bit data plus valid, with stall,
// synchronous flush and a registered count of valid stages.
module dffnrnq_pipe_bank
    import dffnrnq_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_VAL_DEFAULT}}
) (
    input  logic                CLKN,
    input  logic                RN,
    dffnrnq_pipe_bank_if.slave  bus
);

    localparam int unsigned OW = occ_w(DEPTH);

    // Each stage holds {valid, data}; valid lives in the MSB.
    logic [WIDTH:0]   stage [DEPTH];
    logic [DEPTH-1:0] v;
    logic [OW-1:0]    occ;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH:0] din;

        if (i == 0) begin : g_head
            assign din = {bus.DV, bus.D};
        end else begin : g_body
            assign din = stage[i-1];
        end

        dffnrnq_vec #(
            .W        (WIDTH + 1),
            .LOAD_VAL ({1'b0, RESET_VAL})
        ) u_stage (
            .CLKN (CLKN),
            .RN   (RN),
            .EN   (bus.EN),
            .LOAD (bus.FLUSH),
            .D    (din),
            .Q    (stage[i])
        );

        assign v[i] = stage[i][WIDTH];
    end

    // Incoming valid adds one, the valid leaving the last stage removes one.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            occ <= '0;
        end else if (bus.FLUSH) begin
            occ <= '0;
        end else if (bus.EN) begin
            occ <= occ + OW'(bus.DV) - OW'(v[DEPTH-1]);
        end
    end

    assign bus.Q   = stage[DEPTH-1][WIDTH-1:0];
    assign bus.QV  = v[DEPTH-1];
    assign bus.OCC = occ;

    occ_matches_valids: assert property (
        @(negedge CLKN) disable iff (!RN) 32'(occ) == $countones(v)
    );

endmodule

// File: doc/dffnrnq_pipe_bank.md
# dffnrnq_pipe_bank

Parametrised negative-edge pipeline register bank with asynchronous active-low reset. It carries a WIDTH-bit data word plus a valid flag through DEPTH falling-edge stages. It supports stall (EN), synchronous flush, and a registered occupancy counter. It is the multi-bit, multi-stage successor to the single-bit negative-edge reset flop. It sits in half-cycle retiming paths and falling-edge capture interfaces.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of pipeline stages (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into every data stage on reset or flush
- CLKN  in  1  clock; all state updates on the falling edge
- RN  in  1  reset, asynchronous, active-low; asserting it immediately clears all state
- EN  in  1  advance enable; 0 = stall (all state held)
- FLUSH  in  1  synchronous clear, sampled on the falling edge
- D  in  WIDTH  data into stage 0
- DV  in  1  valid flag accompanying D
- Q  out  WIDTH  data of stage DEPTH-1
- QV  out  1  valid flag of stage DEPTH-1
- OCC  out  $clog2(DEPTH+1)  number of stages currently holding valid data

## Operation
- State: data[0..DEPTH-1] (WIDTH each), v[0..DEPTH-1], occ register.
- RN=0 (asynchronous, any time, including mid-stall or mid-flush): data[i]=RESET_VAL, v[i]=0, occ=0. Q=RESET_VAL, QV=0, OCC=0 while RN is low.
- Falling edge with RN=1, priority FLUSH > EN > hold:
  - FLUSH=1: data[i]=RESET_VAL, v[i]=0, occ=0. EN, D and DV are ignored. FLUSH wins over a simultaneous EN.
  - FLUSH=0, EN=1: data[0]=D, v[0]=DV; data[i]=data[i-1], v[i]=v[i-1] for i≥1. occ = occ + DV − v[DEPTH-1], evaluated on pre-edge values.
  - FLUSH=0, EN=0: all state unchanged, including occ.
- Data is captured regardless of DV. Data in an invalid stage is shifted unchanged. No bubble collapsing.
- occ width: $clog2(DEPTH+1). The increment/decrement expression cannot overflow or underflow, because occ always equals popcount(v). A mismatch is a design error, and verification checks for it with an assertion.
- DEPTH=1: data[0]/v[0] feed Q/QV directly. occ toggles between 0 and 1.
- Q, QV and OCC are driven directly from registers, with no combinational path from any input.

## Timing
- Latency: a word presented at D/DV before falling edge k appears at Q/QV after edge k+DEPTH−1. With EN held high, that is DEPTH falling edges after capture starts, counting the capturing edge. Each stalled edge adds one edge of latency.
- Outputs change only after a falling CLKN edge or on assertion of RN. Rising edges have no effect.
- RN deassertion is asynchronous. The first capture happens on the first falling edge after RN goes high. Recovery and removal timing is met by the integrator.
- D, DV, EN and FLUSH must meet setup/hold around the falling edge.

## Structure
- Shared package dffnrnq_pkg holds:
  - the occupancy-width function occ_w(depth) = $clog2(depth+1);
  - the default RESET_VAL constant.
- One sub-module, dffnrnq_vec, implements one stage: a WIDTH+1-bit falling-edge register with async active-low RN, a synchronous load-constant (flush) input, and an enable.
- dffnrnq_pipe_bank instantiates DEPTH dffnrnq_vec stages with a generate loop and adds the occ counter.

## Test plan
- Reset: hold RN=0 across random D/EN/FLUSH with WIDTH=8, DEPTH=4 → Q=8'h00, QV=0, OCC=0 throughout. After RN rises, the first edge with EN=1, D=8'hA5, DV=1 → OCC=1.
- Streaming: EN=1, feed D=1,2,3,4,5 with DV=1 on consecutive falling edges → Q=1 appears after the 4th edge, then 2,3,4,5. OCC reads 1,2,3,4,4,4.
- Stall and bubbles: feed 8'h11 (DV=1), 8'h22 (DV=0), 8'h33 (DV=1), then EN=0 for 3 edges → Q/QV/OCC frozen during the stall. OCC=2 before and after. 8'h22 later emerges with QV=0.
- Flush priority: full pipe (OCC=4), assert FLUSH=1 and EN=1 with D=8'hFF, DV=1 on the same edge → Q=RESET_VAL, QV=0, OCC=0. 8'hFF is never seen.
- Async reset mid-operation: drop RN between falling edges with OCC=3 → Q, QV and OCC clear immediately, without waiting for a clock edge.
- DEPTH=1, WIDTH=1 build: D=1, DV=1 → Q=1, QV=1, OCC=1 after one edge. D=0, DV=0 → OCC=0. Run a random stall/flush soak with the occ==popcount(v) assertion enabled.
